// File: rtl/piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define PISO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             sout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;
`ifdef PISO_TX_PARITY_EN
  logic             par_q;
`endif

  // Outputs are set one state ahead, so each state's line value is already in a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          sout_q <= 1'b1;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (load_i) begin
            shift_q <= din_i;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
`ifdef PISO_TX_PARITY_EN
            par_q   <= ^din_i;
`endif
          end
        end
        START: begin
          sout_q  <= shift_q[0];
          shift_q <= {1'b0, shift_q[WIDTH-1:1]};
          cnt_q   <= '0;
          state_q <= DATA;
        end
        DATA: begin
          if (cnt_q == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
            sout_q  <= par_q;
            state_q <= PARITY;
`else
            sout_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= STOP;
`endif
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            sout_q  <= shift_q[0];
            shift_q <= {1'b0, shift_q[WIDTH-1:1]};
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          sout_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= STOP;
        end
`endif
        STOP: begin
          sout_q  <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          sout_q  <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sout_o = sout_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits per frame (legal range 2..16).
REQ-002 Port: CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: RST  input  1  asynchronous, active-high reset.
REQ-004 Port: LOAD  input  1  request to start a frame; sampled only in IDLE.
REQ-005 Port: DIN  input  WIDTH  parallel data, captured on the edge that accepts LOAD.
REQ-006 Port: SOUT  output  1  registered serial line; idles high.
REQ-007 Port: BUSY  output  1  registered; high from START through STOP inclusive.
REQ-008 Port: DONE  output  1  registered; one-cycle pulse during the STOP cycle.

Function
REQ-009 States SHALL be IDLE, START, DATA, PARITY (only with PARITY_EN), STOP; encoding is free, but no other states are reachable.
REQ-010 IDLE: SOUT=1, BUSY=0, DONE=0; LOAD=1 at an edge SHALL capture DIN into the shift register, clear the bit counter, and enter START.
REQ-011 START SHALL last exactly one cycle with SOUT=0, BUSY=1.
REQ-012 DATA SHALL last exactly WIDTH cycles, driving DIN bits LSB first, one bit per cycle; bit counter counts 0..WIDTH-1 with no wrap.
REQ-013 After the last data bit, the FSM SHALL go to PARITY if compiled in, else to STOP.
REQ-014 STOP SHALL last exactly one cycle with SOUT=1, BUSY=1, DONE=1, then return to IDLE.
REQ-015 Latency: SOUT SHALL show the start bit in the cycle immediately after the accepting edge; frame length = WIDTH+2 cycles (WIDTH+3 with parity).
REQ-016 LOAD while BUSY=1 (including the STOP cycle) SHALL be ignored; DIN changes mid-frame SHALL NOT affect the frame in progress.
REQ-017 LOAD held high continuously SHALL start a new frame on the first edge in IDLE, giving exactly one idle-high cycle between frames.
REQ-018 SOUT, BUSY, DONE SHALL come directly from flops (no combinational path from LOAD/DIN to outputs).

Reset
REQ-019 RST=1 SHALL immediately force: state IDLE, SOUT=1, BUSY=0, DONE=0, shift register 0, bit counter 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no DONE pulse; after release the block SHALL accept LOAD on the first rising edge.
REQ-021 LOAD sampled on the same edge that RST deasserts SHALL be accepted only if RST is low at that edge.

Configuration
REQ-022 Macro PISO_TX_PARITY_EN: when defined, a PARITY state of one cycle SHALL be inserted between DATA and STOP, driving even parity (XOR of all WIDTH data bits); when undefined, no PARITY state, no parity logic, and DATA goes directly to STOP.

Verification
REQ-023 WIDTH=8, no parity, LOAD pulse with DIN=0xA5 -> SOUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, BUSY high 10 cycles, DONE high only in the 10th.
REQ-024 PISO_TX_PARITY_EN defined, DIN=0xA5 -> parity bit 0 in cycle 10, stop in cycle 11; DIN=0x07 -> parity bit 1.
REQ-025 LOAD with DIN=0x3C while busy in the 4th cycle of a 0xA5 frame -> 0xA5 frame unchanged, no second frame starts.
REQ-026 LOAD held high, DIN=0xFF then 0x00 -> back-to-back frames separated by exactly one SOUT=1 idle cycle; second frame carries the DIN sampled at its accept edge.
REQ-027 RST pulse asynchronous to CLK in the 5th data bit -> SOUT=1, BUSY=0 immediately, no DONE; next LOAD with DIN=0x81 produces a complete correct frame.
